// File: rtl/framer_pkg.sv
// Shared constants and types for the audio framer.
// Frame geometry defaults, derived widths and the control-state enum.
package framer_pkg;

  localparam int FRAME_LEN = 512;
  localparam int HOP       = 256;
  localparam int DATA_W    = 16;
  localparam int IDX_W     = $clog2(FRAME_LEN);
  localparam int PTR_W     = $clog2(2 * FRAME_LEN);

  typedef enum logic {
    FILL,
    EMIT
  } state_e;

endpackage

// File: rtl/framer_ram.sv
// Simple dual-port sample RAM: one write port, one registered read port.
// No reset so that it maps onto block RAM.
module framer_ram #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];
  logic [DW-1:0] rdata_q;

  // Write port plus one-cycle synchronous read.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/audio_framer.sv
// Circular-buffer framer emitting overlapping FRAME_LEN-sample frames.
// Optional drop counter enabled by defining FRAMER_DROP_CNT_EN.
module audio_framer #(
  parameter int FRAME_LEN = framer_pkg::FRAME_LEN,
  parameter int HOP       = framer_pkg::HOP,
  parameter int DATA_W    = framer_pkg::DATA_W
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  input  logic [DATA_W-1:0]            in_data,
  output logic                         in_ready,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [DATA_W-1:0]            out_data,
  output logic [$clog2(FRAME_LEN)-1:0] out_index,
  output logic                         out_sof,
  output logic                         out_eof
`ifdef FRAMER_DROP_CNT_EN
  ,
  output logic [15:0]                  drop_cnt
`endif
);

  import framer_pkg::*;

  localparam int IW    = $clog2(FRAME_LEN);
  localparam int PW    = $clog2(2 * FRAME_LEN);
  localparam int DEPTH = 2 * FRAME_LEN;

  localparam logic [PW:0]   FULL_V  = (PW+1)'(DEPTH);
  localparam logic [PW:0]   FRAME_V = (PW+1)'(FRAME_LEN);
  localparam logic [PW:0]   HOP_F   = (PW+1)'(HOP);
  localparam logic [PW-1:0] HOP_P   = PW'(HOP);
  localparam logic [IW-1:0] LAST_I  = IW'(FRAME_LEN - 1);

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   base_q, base_d;
  logic [PW:0]     fill_q, fill_d;
  logic [IW-1:0]   rd_off_q, rd_off_d;
  logic            done_q, done_d;
  logic            s1_valid_q, s1_valid_d;
  logic [IW-1:0]   s1_idx_q, s1_idx_d;
  logic            skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q, skid_data_d;
  logic [IW-1:0]   skid_idx_q, skid_idx_d;
  logic            out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic [IW-1:0]   out_idx_q, out_idx_d;
  logic            out_sof_q, out_sof_d;
  logic            out_eof_q, out_eof_d;

  logic              wr_en;
  logic              frame_end;
  logic              out_load;
  logic              issue;
  logic [PW-1:0]     rd_addr;
  logic [DATA_W-1:0] ram_rdata;

  assign in_ready  = fill_q < FULL_V;
  assign wr_en     = in_valid && in_ready;
  assign frame_end = out_valid_q && out_ready && out_eof_q;
  assign out_load  = !out_valid_q || out_ready;
  assign rd_addr   = base_q + PW'(rd_off_q);

  // Issue a read only when the skid is guaranteed empty next cycle.
  assign issue = (state_q == EMIT) && !done_q && !skid_valid_q &&
                 !(s1_valid_q && out_valid_q && !out_ready);

  framer_ram #(
    .DEPTH (DEPTH),
    .AW    (PW),
    .DW    (DATA_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_en),
    .waddr (wr_ptr_q),
    .wdata (in_data),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  // Next-state: pointers, fill level, frame FSM and read pipeline.
  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q + PW'(wr_en);
    base_d       = base_q;
    fill_d       = fill_q + (PW+1)'(wr_en) - (frame_end ? HOP_F : '0);
    rd_off_d     = rd_off_q;
    done_d       = done_q;
    s1_valid_d   = issue;
    s1_idx_d     = rd_off_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    skid_idx_d   = skid_idx_q;
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    out_idx_d    = out_idx_q;
    out_sof_d    = out_sof_q;
    out_eof_d    = out_eof_q;

    unique case (state_q)
      FILL: begin
        if (fill_q >= FRAME_V) begin
          state_d  = EMIT;
          rd_off_d = '0;
          done_d   = 1'b0;
        end
      end
      EMIT: begin
        if (issue) begin
          rd_off_d = rd_off_q + 1'b1;
          if (rd_off_q == LAST_I) done_d = 1'b1;
        end
        if (frame_end) begin
          base_d  = base_q + HOP_P;
          state_d = FILL;
        end
      end
      default: state_d = FILL;
    endcase

    if (out_load) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        out_idx_d    = skid_idx_q;
        skid_valid_d = s1_valid_q;
        skid_data_d  = ram_rdata;
        skid_idx_d   = s1_idx_q;
      end else if (s1_valid_q) begin
        out_valid_d = 1'b1;
        out_data_d  = ram_rdata;
        out_idx_d   = s1_idx_q;
      end else begin
        out_valid_d = 1'b0;
      end
      out_sof_d = out_valid_d && (out_idx_d == '0);
      out_eof_d = out_valid_d && (out_idx_d == LAST_I);
    end else if (s1_valid_q) begin
      skid_valid_d = 1'b1;
      skid_data_d  = ram_rdata;
      skid_idx_d   = s1_idx_q;
    end
  end

  // State registers with synchronous reset that also aborts any frame.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= FILL;
      wr_ptr_q     <= '0;
      base_q       <= '0;
      fill_q       <= '0;
      rd_off_q     <= '0;
      done_q       <= 1'b0;
      s1_valid_q   <= 1'b0;
      s1_idx_q     <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
      skid_idx_q   <= '0;
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
      out_sof_q    <= 1'b0;
      out_eof_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      base_q       <= base_d;
      fill_q       <= fill_d;
      rd_off_q     <= rd_off_d;
      done_q       <= done_d;
      s1_valid_q   <= s1_valid_d;
      s1_idx_q     <= s1_idx_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
      skid_idx_q   <= skid_idx_d;
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      out_idx_q    <= out_idx_d;
      out_sof_q    <= out_sof_d;
      out_eof_q    <= out_eof_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_idx_q;
  assign out_sof   = out_sof_q;
  assign out_eof   = out_eof_q;

`ifdef FRAMER_DROP_CNT_EN
  logic [15:0] drop_q, drop_d;

  // Saturating count of samples offered while the buffer was full.
  always_comb begin
    drop_d = drop_q;
    if (in_valid && !in_ready && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  // Drop counter register.
  always_ff @(posedge clk) begin
    if (rst) drop_q <= '0;
    else     drop_q <= drop_d;
  end

  assign drop_cnt = drop_q;
`endif

endmodule

// File: tb/tb_audio_framer.sv
// Randomized scoreboard bench for audio_framer.
// Reference model: a queue of accepted samples, framed by index arithmetic.
module tb_audio_framer;

  localparam int FL    = 512;
  localparam int HP    = 256;
  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] out_data;
  logic [8:0]  out_index;
  logic        out_sof;
  logic        out_eof;
`ifdef FRAMER_DROP_CNT_EN
  logic [15:0] drop_cnt;
`endif

  audio_framer dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_index (out_index),
    .out_sof   (out_sof),
    .out_eof   (out_eof)
`ifdef FRAMER_DROP_CNT_EN
    ,
    .drop_cnt  (drop_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  function automatic void chk(bit ok, string name, int act, int exp);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
  endfunction

  // Model state: window of buffered samples, position within frame.
  logic [15:0] win [$];
  int          sof_vals [$];
  int          idx = 0;
  int          frames = 0;
  int          drops = 0;
  int          acc = 0;
  bit          rst_seen = 0;
  bit          stall = 0;
  logic [15:0] s_data;
  logic [8:0]  s_idx;
  logic        s_sof, s_eof;

  // Monitor: samples DUT at negedge, compares with model, updates model.
  always @(negedge clk) begin
    bit exp_rdy;
    int e;
    if (rst) begin
      win.delete();
      sof_vals.delete();
      idx = 0;
      stall = 0;
      drops = 0;
      rst_seen = 1;
    end else begin
      if (rst_seen) begin
        chk(!out_valid, "post_rst_valid", int'(out_valid), 0);
        rst_seen = 0;
      end
      exp_rdy = win.size() < DEPTH;
      chk(in_ready == exp_rdy, "in_ready", int'(in_ready), int'(exp_rdy));
`ifdef FRAMER_DROP_CNT_EN
      chk(int'(drop_cnt) == drops, "drop_cnt_track", int'(drop_cnt), drops);
`endif
      if (stall) begin
        chk(out_valid && out_data == s_data && out_index == s_idx &&
            out_sof == s_sof && out_eof == s_eof,
            "stall_hold", int'(out_data), int'(s_data));
      end
      stall = 0;
      if (out_valid) begin
        if (out_ready) begin
          e = (idx < win.size()) ? int'(win[idx]) : -1;
          chk(int'(out_data) == e, "data", int'(out_data), e);
          chk(int'(out_index) == idx, "index", int'(out_index), idx);
          chk(out_sof == (idx == 0) && out_eof == (idx == FL - 1),
              "sof_eof", int'({out_sof, out_eof}),
              int'({idx == 0, idx == FL - 1}));
          if (idx == 0) sof_vals.push_back(int'(out_data));
          idx++;
          if (idx == FL) begin
            idx = 0;
            frames++;
            repeat (HP) void'(win.pop_front());
          end
        end else begin
          stall = 1;
          s_data = out_data;
          s_idx = out_index;
          s_sof = out_sof;
          s_eof = out_eof;
        end
      end
      if (in_valid && in_ready) acc++;
      if (in_valid) begin
        if (exp_rdy) win.push_back(in_data);
        else if (drops < 65535) drops++;
      end
    end
  end

  task automatic drive(bit v, logic [15:0] d, bit r);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data = d;
    out_ready = r;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1;
    in_valid = 0;
    @(posedge clk);
    #1;
    rst = 0;
  endtask

  int ramp;
  bit hit;
  int f0;

  initial begin
    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk(!out_valid, "reset_valid", int'(out_valid), 0);
    chk(out_index == 0 && !out_sof && !out_eof, "reset_outs",
        int'(out_index), 0);
    chk(in_ready, "reset_ready", int'(in_ready), 1);

    // Continuous ramp, no backpressure.
    ramp = 0;
    repeat (1700) begin
      drive(1, 16'(ramp), 1);
      ramp++;
    end
    chk(sof_vals.size() >= 3, "ramp_frames", sof_vals.size(), 3);
    if (sof_vals.size() >= 3) begin
      chk(sof_vals[0] == 0, "ramp_f0", sof_vals[0], 0);
      chk(sof_vals[1] == 256, "ramp_f1", sof_vals[1], 256);
      chk(sof_vals[2] == 512, "ramp_f2", sof_vals[2], 512);
    end
    repeat (1500) drive(0, '0, 1);

    // Random data, sparse input, 50% output backpressure.
    repeat (4000)
      drive($urandom_range(0, 3) == 0, 16'($urandom), 1'($urandom_range(0, 1)));
    repeat (2500) drive(0, '0, 1);

    // Buffer overflow with output blocked.
    do_reset();
    acc = 0;
    repeat (2000) drive(1, 16'($urandom), 0);
    drive(0, '0, 0);
    @(negedge clk);
    chk(acc == DEPTH, "full_accepted", acc, DEPTH);
    chk(!in_ready, "full_not_ready", int'(in_ready), 0);
    chk(out_valid && out_index == 0, "full_stalled_idx0", int'(out_index), 0);
`ifdef FRAMER_DROP_CNT_EN
    chk(drop_cnt == 16'd976, "drop_cnt_976", int'(drop_cnt), 976);
`endif
    repeat (2000) drive(0, '0, 1);

    // Reset in the middle of a frame.
    do_reset();
    hit = 0;
    ramp = 1000;
    for (int i = 0; i < 2000 && !hit; i++) begin
      drive(1, 16'(ramp), 1);
      ramp++;
      if (out_valid && out_index == 100) hit = 1;
    end
    chk(hit, "wait_idx100", int'(hit), 1);
    rst = 1;
    in_valid = 0;
    @(posedge clk);
    #1 rst = 0;
    ramp = 5000;
    repeat (700) begin
      drive(1, 16'(ramp), 1);
      ramp++;
    end
    repeat (300) drive(0, '0, 1);
    chk(sof_vals.size() >= 1 && sof_vals[0] == 5000, "post_rst_frame",
        sof_vals.size() >= 1 ? sof_vals[0] : -1, 5000);

    // Ramp at half rate across many buffer wraps.
    do_reset();
    f0 = frames;
    ramp = 0;
    for (int i = 0; i < 9000 && frames - f0 < 10; i++) begin
      drive(i % 2 == 0, 16'(ramp), 1);
      if (i % 2 == 0) ramp++;
    end
    chk(frames - f0 >= 10, "wrap_frames", frames - f0, 10);
    for (int k = 0; k < 10; k++)
      if (k < sof_vals.size())
        chk(sof_vals[k] == 256 * k, "wrap_first", sof_vals[k], 256 * k);
    drive(0, '0, 1);
    @(negedge clk);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/audio_framer.md
# audio_framer

Upstream stage of the Hanning multiplier. It accepts a slow, sample-rate stream of 16-bit audio samples and stores them in a circular buffer. It emits overlapping frames of FRAME_LEN samples, advancing by HOP samples per frame, as clock-rate bursts with a frame-relative index. The window ROM address and the FFT input are driven from this index, so they stay aligned with frame boundaries.

## Interface
- FRAME_LEN, 512: samples per frame; power of two.
- HOP, 256: samples between frame starts; power of two, ≤ FRAME_LEN.
- DATA_W, 16: sample width.
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  reset; synchronous, active-high.
- in_valid  in  1  sample present on in_data this cycle.
- in_data  in  DATA_W  signed PCM sample.
- in_ready  out  1  buffer can accept a sample this cycle.
- out_valid  out  1  out_data/out_index valid.
- out_ready  in  1  downstream accepts the current output.
- out_data  out  DATA_W  frame sample.
- out_index  out  log2(FRAME_LEN)  position in frame; drives window ROM address.
- out_sof  out  1  high with out_index==0.
- out_eof  out  1  high with out_index==FRAME_LEN-1.

## Operation
- Buffer: DEPTH=2*FRAME_LEN words (1024 at defaults). Registers: wr_ptr and base, each log2(DEPTH) bits, both wrapping modulo DEPTH.
- fill = wr_ptr − base (mod DEPTH), held in a separate log2(DEPTH)+1-bit counter. Range 0..DEPTH.
- in_ready = (fill < DEPTH). It is combinational from registered state.
- An input is accepted when in_valid && in_ready: mem[wr_ptr] ← in_data, then wr_ptr+1 and fill+1.
- FSM states:
  - FILL: when fill ≥ FRAME_LEN, go to EMIT with rd_off=0.
  - EMIT: read mem[base+rd_off] and present it with out_index=rd_off. rd_off advances on each out_valid&&out_ready. On the handshake with rd_off==FRAME_LEN-1: base += HOP, fill −= HOP, go to FILL.
- Resulting frame content: frame k carries input samples k·HOP … k·HOP+FRAME_LEN−1, in order.
- Simultaneous input write and frame end in the same cycle: fill changes by +1−HOP.
- Writes during EMIT never hit the active frame, because wr_ptr stays within base+FRAME_LEN … base+DEPTH−1.
- Full case: in_ready=0 and in_valid is ignored. The codec does not stall, so the sample is lost; see Configuration.
- Reset values: wr_ptr=0, base=0, fill=0, state=FILL, out_valid=0, out_data=0, out_index=0, out_sof=0, out_eof=0. in_ready=1 from the first cycle after reset.
- Reset mid-EMIT: the frame is aborted and all buffered samples are discarded. out_valid=0 in the cycle after rst is sampled.

## Timing
- RAM read is synchronous with one cycle of latency. The output register adds one more cycle.
- First out_valid appears 2 cycles after the FILL→EMIT transition.
- out_valid, once high, holds out_data/out_index/sof/eof stable until out_ready. A 1-entry skid keeps the read pipeline lossless under backpressure.
- With out_ready held high, a frame is FRAME_LEN consecutive valid cycles. The next frame follows once fill ≥ FRAME_LEN again.
- The input write is visible to the fill comparison in the next cycle.

## Configuration
- FRAMER_DROP_CNT_EN defined:
  - Adds output drop_cnt [15:0], reset 0.
  - It increments on every cycle with in_valid && !in_ready and saturates at 16'hFFFF.
- Undefined: there is no drop_cnt port and dropped samples are silently discarded.

## Structure
- framer_pkg holds:
  - FRAME_LEN, HOP, DATA_W defaults;
  - derived IDX_W=$clog2(FRAME_LEN) and PTR_W=$clog2(2*FRAME_LEN);
  - the state enum {FILL, EMIT}.
- Sub-module framer_ram: simple dual-port RAM, DEPTH×DATA_W, one write port, one synchronous-read port, no reset. It is inferred as block RAM.

## Test plan
- Ramp input 0,1,2,… continuous, out_ready=1 → frame 0 carries 0..511, frame 1 carries 256..767, frame 2 carries 512..1023. sof at index 0, eof at index 511.
- out_ready toggled pseudo-randomly at 50% during a frame → identical data/index sequence to the continuous case, no duplicates or gaps, outputs stable while stalled.
- out_ready=0 permanently while feeding 2000 samples → in_ready falls after 1024 accepted samples.
  - With FRAMER_DROP_CNT_EN: drop_cnt=976.
- Input write coinciding with the eof handshake → fill ends at previous+1−256. The next frame starts at the correct sample.
- rst asserted at out_index=100 → next cycle out_valid=0, fill=0, in_ready=1. After 512 new samples, a frame starting at the first post-reset sample is emitted.
- Ramp wrapping the 1024-entry buffer over 10 frames → every frame's first sample equals 256·k, with no pointer-wrap errors.
